// File: rtl/half_adder.sv
//------------------------------------------------------------------------------
// half_adder: registered bank of independent one-bit half-adder lanes with an
// aggregate carry flag and a saturating carry-event counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             carry_any,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic             w_carry_any;
  logic             w_cnt_inc;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic             r_carry_any;
  logic [CNT_W-1:0] r_count;

  // Each lane sees only its own operand bits; nothing ripples between lanes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign w_sum[i]   = a[i] ^ b[i];
    assign w_carry[i] = a[i] & b[i];
  end

  assign w_carry_any = |w_carry;
  assign w_cnt_inc   = in_valid && w_carry_any && (r_count != CNT_MAX);

  // Result registers only load on accepted inputs so unqualified operands
  // never reach held state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_sum       <= '0;
      r_carry     <= '0;
      r_carry_any <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum       <= w_sum;
        r_carry     <= w_carry;
        r_carry_any <= w_carry_any;
      end
    end
  end

  // Clear wins over a same-cycle increment; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (cnt_clear) begin
      r_count <= '0;
    end else if (w_cnt_inc) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign out_valid   = r_valid;
  assign sum         = r_sum;
  assign carry       = r_carry;
  assign carry_any   = r_carry_any;
  assign carry_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_half_adder.sv
//------------------------------------------------------------------------------
// tb_half_adder: scoreboard bench driving an 8-lane/2-bit-counter instance and
// a 1-lane/16-bit-counter instance from shared stimulus. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_half_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cnt_clear;

  logic        ov8, cany8, ov1, cany1;
  logic [7:0]  sum8, carry8;
  logic [1:0]  cnt8;
  logic [0:0]  sum1, carry1;
  logic [15:0] cnt1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        ov;
    logic [7:0]  sum;
    logic [7:0]  carry;
    logic        cany;
    logic [1:0]  cnt;
    logic        s1;
    logic        c1;
    logic        cany1;
    logic [15:0] cnt1;
  } exp_t;

  exp_t m;
  exp_t q[$];

  always #5 clk = ~clk;

  half_adder #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .cnt_clear(cnt_clear), .out_valid(ov8), .sum(sum8), .carry(carry8),
    .carry_any(cany8), .carry_count(cnt8)
  );

  half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .cnt_clear(cnt_clear), .out_valid(ov1), .sum(sum1), .carry(carry1),
    .carry_any(cany1), .carry_count(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict the next register state, then compare after the edge.
  task automatic step(input logic rst, input logic vld, input logic [7:0] ta,
                      input logic [7:0] tb, input logic clr);
    exp_t e;
    rst_n = rst; in_valid = vld; a = ta; b = tb; cnt_clear = clr;
    if (!rst) begin
      m = '0;
    end else begin
      if (vld) begin
        m.sum   = ta ^ tb;
        m.carry = ta & tb;
        m.cany  = |(ta & tb);
        m.s1    = ta[0] ^ tb[0];
        m.c1    = ta[0] & tb[0];
        m.cany1 = ta[0] & tb[0];
      end
      m.ov = vld;
      if (clr) m.cnt = 2'd0;
      else if (vld && (|(ta & tb)) && m.cnt != 2'd3) m.cnt = m.cnt + 2'd1;
      if (clr) m.cnt1 = 16'd0;
      else if (vld && ta[0] && tb[0] && m.cnt1 != 16'hFFFF) m.cnt1 = m.cnt1 + 16'd1;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      check("out_valid8", ov8, e.ov);
      check("sum8", sum8, e.sum);
      check("carry8", carry8, e.carry);
      check("carry_any8", cany8, e.cany);
      check("count8", cnt8, e.cnt);
      check("out_valid1", ov1, e.ov);
      check("sum1", sum1, e.s1);
      check("carry1", carry1, e.c1);
      check("carry_any1", cany1, e.cany1);
      check("count1", cnt1, e.cnt1);
    end
  endtask

  initial begin
    m = '0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cnt_clear = 1'b0;

    // Reset state
    step(0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'hFF, 8'hFF, 1);
    check("reset_valid", ov8, 0);
    check("reset_count", cnt8, 0);

    // Truth table on lane 0
    step(1, 1, 8'h00, 8'h00, 0);
    check("tt00", {ov1, sum1, carry1}, 3'b100);
    step(1, 1, 8'h00, 8'h01, 0);
    check("tt01", {ov1, sum1, carry1}, 3'b110);
    step(1, 1, 8'h01, 8'h00, 0);
    check("tt10", {ov1, sum1, carry1}, 3'b110);
    step(1, 1, 8'h01, 8'h01, 0);
    check("tt11", {ov1, sum1, carry1}, 3'b101);
    check("tt_count1", cnt1, 1);

    // Multi-lane pattern: no inter-lane carry
    step(1, 1, 8'h0A, 8'h06, 0);
    check("lanes_sum", sum8, 8'h0C);
    check("lanes_carry", carry8, 8'h02);
    check("lanes_any", cany8, 1);

    // Hold with unqualified inputs
    step(1, 1, 8'h01, 8'h01, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 8'h00, 0);
    check("hold_valid", ov1, 0);
    check("hold_sum", sum1, 0);
    check("hold_carry", carry1, 1);
    check("hold_count1", cnt1, 16'd2);

    // Saturation of the 2-bit counter, then clear beating increment
    step(1, 0, 8'h00, 8'h00, 1);
    check("clear_only", cnt8, 0);
    step(1, 1, 8'h01, 8'h01, 0); check("sat1", cnt8, 1);
    step(1, 1, 8'h01, 8'h01, 0); check("sat2", cnt8, 2);
    step(1, 1, 8'h01, 8'h01, 0); check("sat3", cnt8, 3);
    step(1, 1, 8'h01, 8'h01, 0); check("sat4", cnt8, 3);
    step(1, 1, 8'h01, 8'h01, 0); check("sat5", cnt8, 3);
    step(1, 1, 8'h01, 8'h01, 1); check("clear_vs_inc", cnt8, 0);
    check("clear_keeps_valid", ov8, 1);

    // Reset in the middle of a stream
    step(1, 1, 8'h01, 8'h01, 0);
    step(0, 1, 8'h01, 8'h01, 0);
    check("midrst", {ov8, sum8, carry8, cany8, cnt8}, 0);
    step(0, 1, 8'hFF, 8'h0F, 0);
    check("midrst2", {ov8, sum8, carry8, cany8, cnt8}, 0);
    step(1, 1, 8'h03, 8'h01, 0);
    check("post_rst_sum", sum8, 8'h02);
    check("post_rst_carry", carry8, 8'h01);
    check("post_rst_count", cnt8, 1);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      step(1, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered bank of WIDTH independent one-bit half-adder lanes. Each lane computes sum = a XOR b and carry = a AND b.
- Lane results are captured on the rising clock edge, with a valid qualifier.
- Adds an aggregate carry flag and a saturating carry-event counter.
- Used as a leaf arithmetic primitive and as the smoke-test block for the simulation flow.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, 16, width of the carry-event counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies a and b this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- cnt_clear  input  1  synchronous clear of carry_count.
- out_valid  output  1  sum/carry hold a fresh result.
- sum  output  WIDTH  registered per-lane sum, a[i]^b[i].
- carry  output  WIDTH  registered per-lane carry, a[i]&b[i].
- carry_any  output  1  registered OR-reduction of the captured carry vector.
- carry_count  output  CNT_W  count of accepted inputs producing any carry; saturating.

Behaviour:
- All state updates on the rising edge of clk; no asynchronous paths. Reset is synchronous and active-low.
- Reset (rst_n=0 at an edge): sum, carry, carry_any, out_valid and carry_count all become 0.
  - Reset overrides in_valid and cnt_clear.
  - Reset asserted mid-stream discards the in-flight input; out_valid is 0 the cycle after.
- Lanes are fully independent: there is no carry propagation between lanes, and lane i depends only on a[i] and b[i].
- Accept (in_valid=1, rst_n=1):
  - sum <= a^b; carry <= a&b; carry_any <= |(a&b); out_valid <= 1.
- Idle (in_valid=0, rst_n=1):
  - out_valid <= 0.
  - sum, carry and carry_any hold their previous values.
- Latency: exactly 1 cycle from accepted input to out_valid=1. Throughput is one result per cycle; back-to-back accepts give back-to-back out_valid.
- carry_count update priority:
  1. rst_n=0 -> 0.
  2. cnt_clear=1 -> 0. A clear takes precedence over a simultaneous increment, so the result is 0, not 1.
  3. in_valid=1 and |(a&b)=1 -> +1, saturating at 2^CNT_W-1 (never wraps).
  4. Otherwise hold.
- carry_count counts accepted cycles, not lanes: a cycle with several carrying lanes adds 1.
- cnt_clear does not affect sum, carry, carry_any or out_valid.
- a and b are sampled only when in_valid=1; their values are don't-care otherwise.
- No X propagation from unqualified inputs into held state.
- Truth table per lane (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.

Test Plan:
- WIDTH=1, after reset: apply (a,b) = 00, 01, 10, 11 in consecutive cycles with in_valid=1.
  - Following cycles give (sum,carry) = 0,0; 1,0; 1,0; 0,1 with out_valid=1 each cycle.
  - carry_count ends at 1.
- WIDTH=4: a=4'b1010, b=4'b0110, in_valid=1.
  - Next cycle: sum=4'b1100, carry=4'b0010, carry_any=1, out_valid=1.
- Hold: after an accepted a=1,b=1, drive in_valid=0 with a=0,b=0 for 3 cycles.
  - out_valid=0; sum=0 and carry=1 held; carry_count unchanged.
- Saturation with CNT_W=2: 5 consecutive accepted a=1,b=1.
  - carry_count steps 1,2,3,3,3.
  - cnt_clear=1 together with another a=1,b=1 accept gives carry_count=0.
- Reset mid-stream: accept a=1,b=1, then assert rst_n=0 on the next edge while in_valid=1.
  - All outputs 0 for each reset cycle.
  - First accept after release gives a correct result one cycle later.
- Random: 1000 cycles with random a, b, in_valid and cnt_clear at WIDTH=8.
  - Outputs match a cycle-delayed reference model bit-for-bit.
